// File: rtl/regfile_writeback_queue_pkg.sv
// Shared types and widths for the register file writeback path.
// A queue entry carries a destination register id and its write data.
package wb_pkg;

    localparam int REG_ID_W   = 4;
    localparam int REG_DATA_W = 16;
    localparam int NUM_REGS   = 16;

    // "reg" is a keyword, so the register id field is named dst.
    typedef struct packed {
        logic [REG_ID_W-1:0]   dst;
        logic [REG_DATA_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_if.sv
// Writeback request handshakes (memory and ALU) plus the register file write port.
// Valid/ready: a request transfers in a cycle where both valid and ready are 1; ready never depends on a same-cycle pop.
interface regfile_writeback_queue_if;
    import wb_pkg::*;

    logic                  mem_valid;
    logic                  mem_ready;
    logic [REG_ID_W-1:0]   mem_reg;
    logic [REG_DATA_W-1:0] mem_data;
    logic                  alu_valid;
    logic                  alu_ready;
    logic [REG_ID_W-1:0]   alu_reg;
    logic [REG_DATA_W-1:0] alu_data;
    logic [REG_ID_W-1:0]   DstReg;
    logic [REG_DATA_W-1:0] DstData;
    logic                  WriteReg;

    modport master (
        output mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
        input  mem_ready, alu_ready, DstReg, DstData, WriteReg
    );

    modport slave (
        input  mem_valid, mem_reg, mem_data, alu_valid, alu_reg, alu_data,
        output mem_ready, alu_ready, DstReg, DstData, WriteReg
    );

endinterface

// File: rtl/regfile_writeback_queue_fwd_select.sv
// Forwarding search over the queued entries for one read port.
// Walks oldest to youngest so the last match (closest to wr_ptr) wins.
module wb_fwd_select
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  wb_entry_t [DEPTH-1:0]   i_entries,
    input  logic [PTR_W-1:0]        i_rd_ptr,
    input  logic [PTR_W:0]          i_count,
    input  logic [REG_ID_W-1:0]     i_id,
    output logic                    o_hit,
    output logic [REG_DATA_W-1:0]   o_data
);

    always_comb begin
        logic [PTR_W-1:0] w_idx;
        o_hit  = 1'b0;
        o_data = '0;
        w_idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_idx = i_rd_ptr + PTR_W'(i);
            if (((PTR_W+1)'(i) < i_count) && (i_entries[w_idx].dst == i_id)) begin
                o_hit  = 1'b1;
                o_data = i_entries[w_idx].data;
            end
        end
    end

endmodule

// File: rtl/regfile_writeback_queue.sv
// In-order writeback queue feeding the single register file write port,
// with two forwarding lookups over the entries not yet written.
module regfile_writeback_queue
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    regfile_writeback_queue_if.slave  bus,
    input  logic                      hold,
    input  logic [REG_ID_W-1:0]       fwd_reg1,
    input  logic [REG_ID_W-1:0]       fwd_reg2,
    output logic                      fwd_hit1,
    output logic                      fwd_hit2,
    output logic [REG_DATA_W-1:0]     fwd_data1,
    output logic [REG_DATA_W-1:0]     fwd_data2,
    output logic [PTR_W:0]            count,
    output logic                      empty,
    output logic                      full
);

    localparam logic [PTR_W:0] L_DEPTH = (PTR_W+1)'(DEPTH);

    wb_entry_t [DEPTH-1:0] r_mem;
    wb_entry_t             r_last;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W:0]        r_count;

    logic       w_mem_ready, w_alu_ready;
    logic       w_mem_acc, w_alu_acc, w_pop;
    logic [1:0] w_n_acc;
    wb_entry_t  w_head;

    // Ready looks only at registered occupancy, so a pop this cycle never frees a slot early.
    assign w_mem_ready = (r_count <= L_DEPTH - 1'b1);
    assign w_alu_ready = bus.mem_valid ? (r_count <= L_DEPTH - 2'd2) : (r_count <= L_DEPTH - 1'b1);
    assign w_mem_acc   = bus.mem_valid & w_mem_ready;
    assign w_alu_acc   = bus.alu_valid & w_alu_ready;
    assign w_n_acc     = {1'b0, w_mem_acc} + {1'b0, w_alu_acc};
    assign empty       = (r_count == '0);
    assign full        = (r_count == L_DEPTH);
    assign w_pop       = ~empty & ~hold;
    assign count       = r_count;

    // When empty the write port keeps showing the last drained entry rather than a stale slot.
    assign w_head        = empty ? r_last : r_mem[r_rd_ptr];
    assign bus.DstReg    = w_head.dst;
    assign bus.DstData   = w_head.data;
    assign bus.WriteReg  = w_pop;
    assign bus.mem_ready = w_mem_ready;
    assign bus.alu_ready = w_alu_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mem    <= '0;
            r_last   <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            // Memory goes in first so it is the older entry on a dual accept.
            if (w_mem_acc) begin
                r_mem[r_wr_ptr] <= '{dst: bus.mem_reg, data: bus.mem_data};
            end
            if (w_alu_acc) begin
                r_mem[r_wr_ptr + PTR_W'(w_mem_acc)] <= '{dst: bus.alu_reg, data: bus.alu_data};
            end
            if (w_pop) begin
                r_last   <= r_mem[r_rd_ptr];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_wr_ptr <= r_wr_ptr + PTR_W'(w_n_acc);
            r_count  <= r_count + (PTR_W+1)'(w_n_acc) - (PTR_W+1)'(w_pop);
        end
    end

    wb_fwd_select #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd1 (
        .i_entries (r_mem),
        .i_rd_ptr  (r_rd_ptr),
        .i_count   (r_count),
        .i_id      (fwd_reg1),
        .o_hit     (fwd_hit1),
        .o_data    (fwd_data1)
    );

    wb_fwd_select #(.DEPTH(DEPTH), .PTR_W(PTR_W)) u_fwd2 (
        .i_entries (r_mem),
        .i_rd_ptr  (r_rd_ptr),
        .i_count   (r_count),
        .i_id      (fwd_reg2),
        .o_hit     (fwd_hit2),
        .o_data    (fwd_data2)
    );

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Bench for regfile_writeback_queue: directed scenarios then random traffic,
// all compared against a queue-based reference model.
module tb_regfile_writeback_queue;

    localparam int DEPTH = 4;
    localparam int PTR_W = 2;

    logic        clk;
    logic        rst;
    logic        hold;
    logic [3:0]  fwd_reg1, fwd_reg2;
    logic        fwd_hit1, fwd_hit2;
    logic [15:0] fwd_data1, fwd_data2;
    logic [2:0]  count;
    logic        empty, full;

    int checks   = 0;
    int failures = 0;

    // Reference model: {reg, data} entries, front = oldest.
    logic [19:0] exp_q[$];
    logic [19:0] last_e;

    regfile_writeback_queue_if bus ();

    regfile_writeback_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .hold      (hold),
        .fwd_reg1  (fwd_reg1),
        .fwd_reg2  (fwd_reg2),
        .fwd_hit1  (fwd_hit1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data1 (fwd_data1),
        .fwd_data2 (fwd_data2),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic logic [16:0] fwd_model(input logic [3:0] id);
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i][19:16] == id) return {1'b1, exp_q[i][15:0]};
        end
        return 17'h0;
    endfunction

    task automatic drive(input logic mv, input logic [3:0] mr, input logic [15:0] md,
                         input logic av, input logic [3:0] ar, input logic [15:0] ad,
                         input logic h, input logic [3:0] f1, input logic [3:0] f2,
                         input logic r);
        bus.mem_valid = mv; bus.mem_reg = mr; bus.mem_data = md;
        bus.alu_valid = av; bus.alu_reg = ar; bus.alu_data = ad;
        hold = h; fwd_reg1 = f1; fwd_reg2 = f2; rst = r;
    endtask

    task automatic drive_idle(input logic h);
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, h, 4'd0, 4'd0, 1'b0);
    endtask

    // Let inputs settle, then compare every output against the model.
    task automatic settle();
        int          n;
        logic [19:0] head;
        logic [16:0] f1, f2;
        #2;
        n    = exp_q.size();
        head = (n > 0) ? exp_q[0] : last_e;
        f1   = fwd_model(fwd_reg1);
        f2   = fwd_model(fwd_reg2);
        chk("count", 32'(count), 32'(n));
        chk("empty", 32'(empty), 32'(n == 0));
        chk("full", 32'(full), 32'(n == DEPTH));
        chk("mem_ready", 32'(bus.mem_ready), 32'(n <= DEPTH - 1));
        chk("alu_ready", 32'(bus.alu_ready), 32'(bus.mem_valid ? (n <= DEPTH - 2) : (n <= DEPTH - 1)));
        chk("WriteReg", 32'(bus.WriteReg), 32'((n > 0) && !hold));
        chk("DstReg", 32'(bus.DstReg), 32'(head[19:16]));
        chk("DstData", 32'(bus.DstData), 32'(head[15:0]));
        chk("fwd_hit1", 32'(fwd_hit1), 32'(f1[16]));
        chk("fwd_data1", 32'(fwd_data1), 32'(f1[15:0]));
        chk("fwd_hit2", 32'(fwd_hit2), 32'(f2[16]));
        chk("fwd_data2", 32'(fwd_data2), 32'(f2[15:0]));
    endtask

    // Apply the cycle's effect to the model, then move to the next cycle.
    task automatic advance();
        int   n;
        logic mem_acc, alu_acc, pop;
        n       = exp_q.size();
        mem_acc = bus.mem_valid && (n <= DEPTH - 1);
        alu_acc = bus.alu_valid && (bus.mem_valid ? (n <= DEPTH - 2) : (n <= DEPTH - 1));
        pop     = (n > 0) && !hold;
        if (rst) begin
            exp_q.delete();
            last_e = 20'h0;
        end else begin
            if (pop) last_e = exp_q.pop_front();
            if (mem_acc) exp_q.push_back({bus.mem_reg, bus.mem_data});
            if (alu_acc) exp_q.push_back({bus.alu_reg, bus.alu_data});
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push_alu(input logic [3:0] r, input logic [15:0] d, input logic h);
        drive(1'b0, 4'd0, 16'h0, 1'b1, r, d, h, 4'd0, 4'd0, 1'b0);
        settle();
        advance();
    endtask

    logic [15:0] fill_tab [4];

    initial begin
        last_e = 20'h0;
        drive_idle(1'b0);
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);

        // Reset state
        drive_idle(1'b0);
        settle();
        chk("rst_WriteReg", 32'(bus.WriteReg), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_DstReg", 32'(bus.DstReg), 32'd0);
        chk("rst_DstData", 32'(bus.DstData), 32'd0);
        chk("rst_ready", 32'({bus.mem_ready, bus.alu_ready}), 32'd3);
        advance();

        // Single ALU write
        push_alu(4'd5, 16'hBEEF, 1'b0);
        drive_idle(1'b0);
        settle();
        chk("single_we", 32'(bus.WriteReg), 32'd1);
        chk("single_reg", 32'(bus.DstReg), 32'd5);
        chk("single_data", 32'(bus.DstData), 32'hBEEF);
        advance();
        drive_idle(1'b0);
        settle();
        chk("single_empty", 32'(empty), 32'd1);
        advance();

        // Dual accept: memory older than ALU, forwarding sees the younger
        drive(1'b1, 4'd3, 16'h1111, 1'b1, 4'd3, 16'h2222, 1'b0, 4'd3, 4'd3, 1'b0);
        settle();
        chk("dual_same_cycle_hit", 32'(fwd_hit1), 32'd0);
        advance();
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd3, 4'd0, 1'b0);
        settle();
        chk("dual_fwd", 32'(fwd_data1), 32'h2222);
        chk("dual_first", 32'(bus.DstData), 32'h1111);
        advance();
        drive_idle(1'b0);
        settle();
        chk("dual_second", 32'(bus.DstData), 32'h2222);
        chk("dual_second_we", 32'(bus.WriteReg), 32'd1);
        advance();

        // Fill under hold, ALU throttled first
        fill_tab[0] = 16'hA000; fill_tab[1] = 16'hA001; fill_tab[2] = 16'hA002; fill_tab[3] = 16'hD003;
        for (int i = 0; i < 3; i++) push_alu(4'(i + 1), fill_tab[i], 1'b1);
        drive(1'b1, 4'd4, fill_tab[3], 1'b1, 4'd5, 16'hEEEE, 1'b1, 4'd0, 4'd0, 1'b0);
        settle();
        chk("fill3_mem_ready", 32'(bus.mem_ready), 32'd1);
        chk("fill3_alu_ready", 32'(bus.alu_ready), 32'd0);
        advance();
        drive(1'b0, 4'd0, 16'h0, 1'b1, 4'd6, 16'h6666, 1'b1, 4'd0, 4'd0, 1'b0);
        settle();
        chk("fill_full", 32'(full), 32'd1);
        chk("fill_alu_ready", 32'(bus.alu_ready), 32'd0);
        advance();
        for (int i = 0; i < 4; i++) begin
            drive_idle(1'b0);
            settle();
            chk("drain_we", 32'(bus.WriteReg), 32'd1);
            chk("drain_data", 32'(bus.DstData), 32'(fill_tab[i]));
            advance();
        end

        // Pointer wrap with back-to-back single pushes
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 4'd0, 16'h0, 1'b1, 4'(i), 16'h5000 + 16'(i), 1'b0, 4'd0, 4'd0, 1'b0);
            settle();
            chk("wrap_cnt_le1", 32'(count <= 3'd1), 32'd1);
            advance();
        end
        drive_idle(1'b0);
        settle();
        chk("wrap_last", 32'(bus.DstData), 32'h5009);
        advance();

        // Forwarding miss/hit while held
        push_alu(4'd7, 16'h00AA, 1'b1);
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 4'd8, 1'b0);
        settle();
        chk("fwd_miss_hit", 32'(fwd_hit2), 32'd0);
        chk("fwd_miss_data", 32'(fwd_data2), 32'd0);
        advance();
        drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b1, 4'd0, 4'd7, 1'b0);
        settle();
        chk("fwd_hit", 32'(fwd_hit2), 32'd1);
        chk("fwd_hit_data", 32'(fwd_data2), 32'h00AA);
        advance();

        // Reset mid-operation, with a request in the reset cycle
        push_alu(4'd9, 16'h9999, 1'b1);
        push_alu(4'd10, 16'hAAAA, 1'b1);
        drive(1'b1, 4'd11, 16'hBBBB, 1'b1, 4'd12, 16'hCCCC, 1'b1, 4'd0, 4'd0, 1'b1);
        settle();
        advance();
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 4'd0, 16'h0, 1'b0, 4'd0, 16'h0, 1'b0, 4'd11, 4'd12, 1'b0);
            settle();
            chk("rstmid_count", 32'(count), 32'd0);
            chk("rstmid_we", 32'(bus.WriteReg), 32'd0);
            chk("rstmid_reg", 32'(bus.DstReg), 32'd0);
            advance();
        end

        // Random traffic
        for (int c = 0; c < 600; c++) begin
            drive(1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 3)), 16'($urandom),
                  1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 4)), 4'($urandom_range(0, 4)),
                  1'($urandom_range(0, 49) == 0));
            settle();
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
